input_deserializer: RTL and testbench
=====================================

# input_deserializer

Serial-to-parallel front end that assembles framed, LSB-first serial bits into WIDTH-bit words. It presents each completed word on a parallel bus with a valid/ready handshake. It sits directly upstream of the 8-input registered AND-chain stage: DATA_OUT[0..7] drive IN1..IN8, and the shared CLK is used throughout. It provides one word of output buffering so that a new word can be collected while the previous one waits.

## Interface
- WIDTH, 8, parallel word width in bits; legal range 2..32.
- CLK  input  1  rising-edge clock, shared with the downstream stage.
- RST_N  input  1  asynchronous, active-low reset.
- SER_IN  input  1  serial data bit; sampled only when SER_EN=1.
- SER_EN  input  1  bit strobe; one serial bit is consumed per cycle that this is high.
- FRAME  input  1  word-start marker; when high with SER_EN, the current bit is bit 0 of a new word.
- DATA_OUT  output  WIDTH  completed word; bit 0 is the first serial bit received.
- DATA_VALID  output  1  DATA_OUT holds an unconsumed word.
- DATA_READY  input  1  consumer accepts the word when DATA_VALID=1 and DATA_READY=1.
- OVERRUN  output  1  one-cycle pulse when a completed word is dropped because the output buffer is full.
- FRAME_ERR  output  1  one-cycle pulse when FRAME arrives while a word is only partly collected.

## Operation
- Shifter FSM has two states, IDLE and SHIFT. It keeps a bit count CNT of width $clog2(WIDTH+1).
- IDLE:
  - SER_EN=1 and FRAME=1: store the bit at position 0, set CNT=1, go to SHIFT.
  - SER_EN=1 and FRAME=0: ignore the bit (no framing yet) and stay in IDLE.
- SHIFT:
  - SER_EN=1 and FRAME=0: store the bit at position CNT, then CNT+1.
  - SER_EN=0: hold everything; gaps of any length are legal.
  - SER_EN=1 and FRAME=1: discard the partial word, pulse FRAME_ERR, store the bit at position 0, set CNT=1, stay in SHIFT.
- Word completion happens when the bit at position WIDTH-1 is stored. The assembled word then goes to the output stage and the FSM returns to IDLE, so the next word needs FRAME again.
- Output stage is one register (DATA_OUT) plus a valid flag:
  - Completion with DATA_VALID=0: load the word and set DATA_VALID=1.
  - Completion with DATA_VALID=1 and DATA_READY=1 in the same cycle: load the new word; DATA_VALID stays 1.
  - Completion with DATA_VALID=1 and DATA_READY=0: keep the old word unchanged, drop the new word, pulse OVERRUN.
  - Accept with no completion in that cycle: DATA_VALID goes to 0. DATA_OUT keeps its last value.
- DATA_OUT is stable whenever DATA_VALID=1 and no accept is occurring.
- Reset (asynchronous assertion, at any time including mid-word or with a word pending):
  - FSM=IDLE, CNT=0, shift register=0.
  - DATA_OUT=0, DATA_VALID=0, OVERRUN=0, FRAME_ERR=0.
  - Any pending or partial word is lost.
- Reset deassertion: the first edge after RST_N rises is a normal functional edge.

## Timing
- Latency: the last bit is sampled at edge N, and DATA_VALID and DATA_OUT are updated by edge N, so they are visible during cycle N+1.
- Back-to-back operation: with SER_EN held high and FRAME every WIDTH cycles, a word completes every WIDTH cycles. This is full throughput when DATA_READY=1.
- A handshake completes on the edge where DATA_VALID=1 and DATA_READY=1. DATA_READY can be high while DATA_VALID=0; this has no effect.
- OVERRUN and FRAME_ERR are registered and high for exactly the cycle after the event edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared package holds:
  - the state enum {IDLE, SHIFT}, with 1-bit encoding;
  - the DESER_WIDTH_DEFAULT=8 constant;
  - a cnt_w(WIDTH) function returning $clog2(WIDTH+1).
- One natural sub-module is deser_out_buf: the output register, valid flag, and overrun logic, fed by a completion strobe plus the word. The FSM and shifter stay in the top module.

## Test plan
- Reset with WIDTH=8: drive FRAME on the first bit and send 1,0,1,1,0,0,1,0 with SER_EN high. Expect DATA_OUT=8'h4D and DATA_VALID=1 one cycle after the 8th bit; with DATA_READY=1, DATA_VALID drops on the next edge.
- Send word 8'hFF with DATA_READY=0, then word 8'h01. Expect OVERRUN to pulse once, DATA_OUT to stay 8'hFF until accepted, and 8'h01 never to appear.
- Send 3 bits, then FRAME with the bits of 8'hA5. Expect a FRAME_ERR pulse at the restart and DATA_OUT=8'hA5 with no OVERRUN.
- Send 8'h3C with SER_EN gaps of 0, 1, and 5 cycles between bits. Expect DATA_OUT=8'h3C and completion exactly one cycle after the last strobed bit.
- Send continuous words 8'h11 then 8'h22 with DATA_READY asserted only on the completion edge of 8'h22. Expect DATA_VALID to stay 1, DATA_OUT to change from 8'h11 to 8'h22, and no OVERRUN.
- Assert RST_N low mid-word (after 4 bits) and again while DATA_VALID=1. Expect all outputs 0 immediately without waiting for a clock edge, and the next framed word 8'h80 to be received correctly.

Source files
------------

// File: rtl/input_deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel front end.
// Holds the shifter state encoding and the bit-count width helper.
package input_deserializer_pkg;

  localparam int DESER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/input_deserializer_out_buf.sv
// One-word output holding register with valid flag.
// Drops a completed word and pulses overrun when the slot is still occupied.
module deser_out_buf
  import input_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  // Load, accept or drop; overrun is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data  <= word;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/input_deserializer.sv
// Framed LSB-first serial to WIDTH-bit parallel word assembler.
// The shifter FSM lives here; the output slot is deser_out_buf.
module input_deserializer
  import input_deserializer_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SER_IN,
  input  logic             SER_EN,
  input  logic             FRAME,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             DATA_VALID,
  input  logic             DATA_READY,
  output logic             OVERRUN,
  output logic             FRAME_ERR
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] bit_vec, word_nx;
  logic             done, ferr_nx;

  assign bit_vec = {{(WIDTH-1){1'b0}}, SER_IN};
  assign word_nx = shreg | (bit_vec << cnt);

  // Next-state, bit placement and completion strobe.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    done     = 1'b0;
    ferr_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (SER_EN && FRAME) begin
          shreg_nx = bit_vec;
          cnt_nx   = ONE;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (SER_EN) begin
          if (FRAME) begin
            ferr_nx  = 1'b1;
            shreg_nx = bit_vec;
            cnt_nx   = ONE;
          end else if (cnt == LAST) begin
            done     = 1'b1;
            shreg_nx = '0;
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            shreg_nx = word_nx;
            cnt_nx   = cnt + ONE;
          end
        end
      end
    endcase
  end

  // Shifter state, count, partial word and frame-error pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      FRAME_ERR <= ferr_nx;
    end
  end

  deser_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk     (CLK),
    .rst_n   (RST_N),
    .done    (done),
    .word    (word_nx),
    .ready   (DATA_READY),
    .data    (DATA_OUT),
    .valid   (DATA_VALID),
    .overrun (OVERRUN)
  );

endmodule

// File: tb/tb_input_deserializer.sv
// Directed bench for input_deserializer at WIDTH=8.
// Inputs change and outputs are checked on the falling edge.
module tb_input_deserializer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SER_IN;
  logic       SER_EN;
  logic       FRAME;
  logic [7:0] DATA_OUT;
  logic       DATA_VALID;
  logic       DATA_READY;
  logic       OVERRUN;
  logic       FRAME_ERR;

  int tests = 0;
  int fails = 0;

  input_deserializer #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SER_IN     (SER_IN),
    .SER_EN     (SER_EN),
    .FRAME      (FRAME),
    .DATA_OUT   (DATA_OUT),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .OVERRUN    (OVERRUN),
    .FRAME_ERR  (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic f);
    SER_IN = b;
    FRAME  = f;
    SER_EN = 1'b1;
    @(negedge CLK);
    SER_EN = 1'b0;
    FRAME  = 1'b0;
    SER_IN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i], i == 0);
  endtask

  task automatic accept();
    DATA_READY = 1'b1;
    @(negedge CLK);
    DATA_READY = 1'b0;
  endtask

  int gaps[7] = '{0, 1, 5, 0, 1, 5, 0};
  logic [7:0] w;

  initial begin
    RST_N = 1'b0;
    SER_IN = 1'b0;
    SER_EN = 1'b0;
    FRAME = 1'b0;
    DATA_READY = 1'b0;
    idle(2);
    chk("rst_data", 32'(DATA_OUT), 32'h0);
    chk("rst_valid", 32'(DATA_VALID), 32'h0);
    chk("rst_ovr", 32'(OVERRUN), 32'h0);
    chk("rst_ferr", 32'(FRAME_ERR), 32'h0);
    RST_N = 1'b1;

    // Basic word 0x4D
    send_word(8'h4D);
    chk("w4d_data", 32'(DATA_OUT), 32'h4D);
    chk("w4d_valid", 32'(DATA_VALID), 32'h1);
    accept();
    chk("w4d_acc_valid", 32'(DATA_VALID), 32'h0);
    chk("w4d_acc_data", 32'(DATA_OUT), 32'h4D);

    // Overrun: 0xFF held, 0x01 dropped
    send_word(8'hFF);
    chk("wff_valid", 32'(DATA_VALID), 32'h1);
    chk("wff_ovr0", 32'(OVERRUN), 32'h0);
    send_word(8'h01);
    chk("ovr_pulse", 32'(OVERRUN), 32'h1);
    chk("ovr_keep", 32'(DATA_OUT), 32'hFF);
    idle(1);
    chk("ovr_end", 32'(OVERRUN), 32'h0);
    chk("ovr_keep2", 32'(DATA_OUT), 32'hFF);
    accept();
    chk("ovr_acc_valid", 32'(DATA_VALID), 32'h0);
    chk("ovr_acc_data", 32'(DATA_OUT), 32'hFF);

    // Frame error: 3 bits then restart with 0xA5
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("ferr_pre", 32'(FRAME_ERR), 32'h0);
    w = 8'hA5;
    send_bit(w[0], 1'b1);
    chk("ferr_pulse", 32'(FRAME_ERR), 32'h1);
    for (int i = 1; i < 8; i++) send_bit(w[i], 1'b0);
    chk("ferr_end", 32'(FRAME_ERR), 32'h0);
    chk("wa5_data", 32'(DATA_OUT), 32'hA5);
    chk("wa5_valid", 32'(DATA_VALID), 32'h1);
    chk("wa5_ovr", 32'(OVERRUN), 32'h0);
    accept();

    // Gapped strobes: 0x3C
    w = 8'h3C;
    for (int i = 0; i < 7; i++) begin
      send_bit(w[i], i == 0);
      idle(gaps[i]);
    end
    chk("w3c_pre_valid", 32'(DATA_VALID), 32'h0);
    send_bit(w[7], 1'b0);
    chk("w3c_data", 32'(DATA_OUT), 32'h3C);
    chk("w3c_valid", 32'(DATA_VALID), 32'h1);
    accept();

    // Back-to-back 0x11 then 0x22, ready only on 0x22 completion edge
    send_word(8'h11);
    chk("w11_data", 32'(DATA_OUT), 32'h11);
    chk("w11_valid", 32'(DATA_VALID), 32'h1);
    w = 8'h22;
    for (int i = 0; i < 7; i++) send_bit(w[i], i == 0);
    chk("w11_hold", 32'(DATA_OUT), 32'h11);
    DATA_READY = 1'b1;
    send_bit(w[7], 1'b0);
    DATA_READY = 1'b0;
    chk("w22_data", 32'(DATA_OUT), 32'h22);
    chk("w22_valid", 32'(DATA_VALID), 32'h1);
    chk("w22_ovr", 32'(OVERRUN), 32'h0);
    idle(1);
    chk("w22_stay", 32'(DATA_VALID), 32'h1);
    accept();

    // Async reset mid-word
    w = 8'hF0;
    for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
    #2 RST_N = 1'b0;
    #1;
    chk("amid_data", 32'(DATA_OUT), 32'h0);
    chk("amid_valid", 32'(DATA_VALID), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);

    // Async reset with a word pending
    send_word(8'hFF);
    chk("apend_pre", 32'(DATA_VALID), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    chk("apend_data", 32'(DATA_OUT), 32'h0);
    chk("apend_valid", 32'(DATA_VALID), 32'h0);
    chk("apend_ovr", 32'(OVERRUN), 32'h0);
    chk("apend_ferr", 32'(FRAME_ERR), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    send_word(8'h80);
    chk("w80_data", 32'(DATA_OUT), 32'h80);
    chk("w80_valid", 32'(DATA_VALID), 32'h1);
    chk("w80_ferr", 32'(FRAME_ERR), 32'h0);
    accept();
    chk("w80_acc", 32'(DATA_VALID), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
